name_scan_ctrl: RTL and testbench

//  Sequencer for the IMTIYAZ letter-pattern detector. Buffers a byte stream of

---
 rtl/name_scan_pkg.sv | 9 +
 rtl/name_scan_if.sv | 9 +
 rtl/scan_fifo.sv | 30 +++
 rtl/name_scan_ctrl.sv | 79 +++++++
 tb/tb_name_scan_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/name_scan_pkg.sv
// name_scan_pkg: shared FSM states, idle letter and FIFO entry type for the letter scan sequencer
package name_scan_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, DONE} state_t;
  localparam logic [7:0] FILL_DEF = 8'h00;
  typedef struct packed {
    logic       last;
    logic [7:0] letter;
  } entry_t;
endpackage

// File: rtl/name_scan_if.sv
// name_scan_if: valid/ready letter stream from the character source into the sequencer
interface name_scan_if;
  logic       in_valid;
  logic [7:0] in_letter;
  logic       in_last;
  logic       in_ready;
  modport master (output in_valid, in_letter, in_last, input in_ready);
  modport slave (input in_valid, in_letter, in_last, output in_ready);
endinterface

// File: rtl/scan_fifo.sv
// scan_fifo: DEPTH-entry {last,letter} buffer with wrap-bit pointers and async reset
module scan_fifo import name_scan_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  output logic   full,
  input  logic   pop,
  output entry_t dout,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/name_scan_ctrl.sv
// name_scan_ctrl: buffers messages, clears and feeds the letter detector, reports match positions and per-message totals
module name_scan_ctrl import name_scan_pkg::*; #(
  parameter int         DEPTH   = 4,
  parameter int         POS_W   = 8,
  parameter int         CNT_W   = 4,
  parameter int         DET_LAT = 1,
  parameter logic [7:0] FILL    = FILL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  name_scan_if.slave       in_if,
  output logic             det_rst,
  output logic [7:0]       det_letter,
  input  logic             det_hit,
  output logic             match_valid,
  output logic [POS_W-1:0] match_pos,
  output logic             msg_done,
  output logic [CNT_W-1:0] match_count,
  output logic             underrun,
  output logic             busy
);
  localparam int DW = $clog2(DET_LAT + 1);
  state_t state, next;
  entry_t head;
  logic full, empty, pop;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] count;
  logic [DW-1:0] drain;
  logic [DET_LAT:0] real_line;
  logic [POS_W-1:0] tag_line [DET_LAT+1];
  scan_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_if.in_valid),
    .din   (entry_t'({in_if.in_last, in_if.in_letter})),
    .full  (full),
    .pop   (pop),
    .dout  (head),
    .empty (empty)
  );
  assign in_if.in_ready = !full;
  assign pop = state == SCAN && !empty;
  assign busy = state != IDLE;
  assign msg_done = state == DONE;
  assign match_valid = det_hit && real_line[DET_LAT];
  assign match_pos = tag_line[DET_LAT];
  assign match_count = count + CNT_W'(match_valid && !(&count));
  always_comb begin
    next = state == IDLE  ? (empty ? IDLE : CLEAR)
         : state == CLEAR ? SCAN
         : state == SCAN  ? ((pop && head.last) ? DRAIN : SCAN)
         : state == DRAIN ? ((drain == DW'(DET_LAT - 1)) ? DONE : DRAIN)
         : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      det_rst <= 1'b1;
      det_letter <= FILL;
      pos <= '0;
      count <= '0;
      drain <= '0;
      underrun <= 1'b0;
      real_line <= '0;
      for (int i = 0; i <= DET_LAT; i++) tag_line[i] <= '0;
    end else begin
      det_rst <= next == CLEAR;
      det_letter <= pop ? head.letter : FILL;
      pos <= state == CLEAR ? '0 : pos + POS_W'(pop);
      count <= state == CLEAR ? '0 : match_count;
      drain <= state == DRAIN ? drain + 1'b1 : '0;
      underrun <= state == CLEAR ? 1'b0 : underrun || (state == SCAN && empty);
      real_line <= {real_line[DET_LAT-1:0], pop};
      tag_line[0] <= pos;
      for (int i = 1; i <= DET_LAT; i++) tag_line[i] <= tag_line[i-1];
    end
endmodule

// File: tb/tb_name_scan_ctrl.sv
// tb_name_scan_ctrl: table, directed and random checks of name_scan_ctrl driving a behavioural IMTIYAZ detector
module tb_name_scan_ctrl;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    string msg;
    int    cnt;
    int    pos;
  } vec_t;
  localparam logic [55:0] PAT = "IMTIYAZ";
  string pat_s = "IMTIYAZ";
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  name_scan_if ifc();
  logic       det_rst, det_hit, match_valid, msg_done, underrun, busy;
  logic [7:0] det_letter, match_pos;
  logic [3:0] match_count;
  name_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (ifc),
    .det_rst     (det_rst),
    .det_letter  (det_letter),
    .det_hit     (det_hit),
    .match_valid (match_valid),
    .match_pos   (match_pos),
    .msg_done    (msg_done),
    .match_count (match_count),
    .underrun    (underrun),
    .busy        (busy)
  );
  logic [47:0] hist;
  always_ff @(posedge clk or posedge det_rst)
    if (det_rst) begin
      hist <= '0;
      det_hit <= 1'b0;
    end else begin
      hist <= {hist[39:0], det_letter};
      det_hit <= {hist, det_letter} == PAT;
    end
  int total = 0, bad = 0;
  int got_pos[$], got_cnt[$], got_und[$], exp_pos[$], exp_cnt[$], exp_und[$];
  logic [7:0] got_let[$], exp_let[$];
  int rst_pulses = 0;
  bit saw_stall = 0;
  always @(negedge clk)
    if (!rst) begin
      if (match_valid) got_pos.push_back(int'(match_pos));
      if (msg_done) begin
        got_cnt.push_back(int'(match_count));
        got_und.push_back(int'(underrun));
      end
      if (det_letter != 8'h00) got_let.push_back(det_letter);
      if (det_rst) rst_pulses++;
      if (ifc.in_valid && !ifc.in_ready) saw_stall = 1;
    end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] l, input logic lst);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_letter = l;
    ifc.in_last = lst;
    while (!ifc.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n == 1000) check("push ready timeout", n, 0);
    else exp_let.push_back(l);
    @(negedge clk);
  endtask
  task automatic send(input bq_t m);
    for (int i = 0; i < m.size(); i++) push(m[i], i == m.size() - 1);
    ifc.in_valid = 1'b0;
    ifc.in_last = 1'b0;
  endtask
  task automatic wait_done(input int n);
    int k = 0;
    while (got_cnt.size() < n && k < 20000) begin
      @(negedge clk);
      #1;
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask
  function automatic bq_t cat(input bq_t a, input string s);
    bq_t q = a;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction
  function automatic void model(input bq_t m);
    int c = 0;
    for (int i = 6; i < m.size(); i++) begin
      bit ok = 1;
      for (int j = 0; j < 7; j++) if (m[i-6+j] != pat_s[j]) ok = 0;
      if (ok) begin
        exp_pos.push_back(i % 256);
        c++;
      end
    end
    exp_cnt.push_back(c > 15 ? 15 : c);
    exp_und.push_back(0);
  endfunction
  function automatic bq_t rand_msg();
    bq_t q;
    string al = "IMTYAZp";
    int n = $urandom_range(1, 20);
    for (int i = 0; i < n; i++) q.push_back(al[$urandom_range(0, 6)]);
    if ($urandom_range(0, 2) == 0) begin
      int at = $urandom_range(0, q.size());
      for (int j = 0; j < 7; j++) q.insert(at + j, pat_s[j]);
    end
    return q;
  endfunction
  task automatic clear_q();
    got_pos.delete(); got_cnt.delete(); got_und.delete(); got_let.delete();
    exp_pos.delete(); exp_cnt.delete(); exp_und.delete(); exp_let.delete();
  endtask
  task automatic compare(input string tag);
    int n, mism;
    check({tag, " msg_done count"}, got_cnt.size(), exp_cnt.size());
    n = got_cnt.size() < exp_cnt.size() ? got_cnt.size() : exp_cnt.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " match_count"}, got_cnt[i], exp_cnt[i]);
      check({tag, " underrun"}, got_und[i], exp_und[i]);
    end
    check({tag, " match_valid count"}, got_pos.size(), exp_pos.size());
    n = got_pos.size() < exp_pos.size() ? got_pos.size() : exp_pos.size();
    for (int i = 0; i < n; i++) check({tag, " match_pos"}, got_pos[i], exp_pos[i]);
    check({tag, " letters fed"}, got_let.size(), exp_let.size());
    mism = 0;
    n = got_let.size() < exp_let.size() ? got_let.size() : exp_let.size();
    for (int i = 0; i < n; i++) if (got_let[i] != exp_let[i]) mism++;
    check({tag, " letter order"}, mism, 0);
    clear_q();
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, " det_rst"}, int'(det_rst), 1);
    check({tag, " det_letter"}, int'(det_letter), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " in_ready"}, int'(ifc.in_ready), 1);
    check({tag, " match_valid"}, int'(match_valid), 0);
    check({tag, " msg_done"}, int'(msg_done), 0);
    check({tag, " match_count"}, int'(match_count), 0);
    check({tag, " underrun"}, int'(underrun), 0);
  endtask
  initial begin
    vec_t tv[5];
    bq_t m;
    tv[0] = '{"pppppIMTIMTIYAZAI", 1, 14};
    tv[1] = '{"IMTIYAZ", 1, 6};
    tv[2] = '{"IMTIYAZ", 1, 6};
    tv[3] = '{"IMTIYA", 0, -1};
    tv[4] = '{"Z", 0, -1};
    ifc.in_valid = 1'b0;
    ifc.in_letter = 8'h00;
    ifc.in_last = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    check("det_rst after release", int'(det_rst), 0);
    rst_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      m.delete();
      send(cat(m, tv[i].msg));
      exp_cnt.push_back(tv[i].cnt);
      exp_und.push_back(0);
      if (tv[i].pos >= 0) exp_pos.push_back(tv[i].pos);
    end
    wait_done(5);
    compare("table");
    check("det_rst pulses", rst_pulses, 5);
    saw_stall = 0;
    for (int i = 0; i < 8; i++) begin
      push(8'h61 + 8'(i), 1'b1);
      exp_cnt.push_back(0);
      exp_und.push_back(0);
    end
    ifc.in_valid = 1'b0;
    ifc.in_last = 1'b0;
    wait_done(8);
    compare("burst");
    check("burst in_ready dropped", int'(saw_stall), 1);
    push("I", 1'b0);
    push("M", 1'b0);
    push("T", 1'b0);
    ifc.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    m.delete();
    send(cat(m, "IYAZ"));
    exp_cnt.push_back(0);
    exp_und.push_back(1);
    wait_done(1);
    compare("underrun");
    check("underrun held", int'(underrun), 1);
    check("busy idle", int'(busy), 0);
    m.delete();
    send(cat(m, "IMTIYAZ"));
    repeat (2) @(negedge clk);
    check("busy mid scan", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid reset");
    clear_q();
    @(negedge clk);
    #2 rst = 1'b0;
    m.delete();
    send(cat(m, "IMTIYAZ"));
    exp_cnt.push_back(1);
    exp_und.push_back(0);
    exp_pos.push_back(6);
    wait_done(1);
    compare("after reset");
    for (int r = 0; r < 27; r++) begin
      m.delete();
      if (r == 25) begin
        for (int i = 0; i < 249; i++) m.push_back("p");
        m = cat(cat(m, "IMTIYAZ"), "IMTIYAZ");
      end else if (r == 26) begin
        for (int i = 0; i < 17; i++) m = cat(m, "IMTIYAZ");
      end else m = rand_msg();
      model(m);
      send(m);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done(27);
    compare("random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
